// File: rtl/cpu_step_pkg.sv
// rtl/cpu_step_pkg.sv - mode encodings and default debounce length for cpu_step_ctrl
package cpu_step_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser and debouncer with a rising-level pulse
module btn_debounce
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_p
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The count only advances while the synced input disagrees with the accepted level.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      rise_p <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        level  <= sync2;
        rise_p <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - RUN/HALT/STEP clock-enable generator; CPU_STEP_CYCLE_COUNT_EN adds a pulse counter
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 32
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_count
);

  logic       div_sync1;
  logic       div_sync2;
  logic       div_prev;
  logic       tick;
  logic       run_p;
  logic       step_p;
  logic       run_level;
  logic       step_level;
  logic       unused_levels;
  logic [1:0] state;
  logic [1:0] state_next;
  logic       ce_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .btn_raw   (btn_run),
    .level     (run_level),
    .rise_p    (run_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .btn_raw   (btn_step),
    .level     (step_level),
    .rise_p    (step_p)
  );

  assign unused_levels = run_level ^ step_level;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_sync1 <= 1'b0;
      div_sync2 <= 1'b0;
      div_prev  <= 1'b0;
    end else begin
      div_sync1 <= clk_div;
      div_sync2 <= div_sync1;
      div_prev  <= div_sync2;
    end
  end

  assign tick = div_sync2 & ~div_prev;

  // halt_req wins over ticks and run toggles; in HALT it only blocks RUN entry.
  always_comb begin
    state_next = state;
    ce_next    = 1'b0;
    case (state)
      MODE_HALT: begin
        if (run_p && !halt_req) begin
          state_next = MODE_RUN;
        end else if (step_p) begin
          state_next = MODE_STEP;
          ce_next    = 1'b1;
        end
      end
      MODE_RUN: begin
        if (halt_req || run_p) begin
          state_next = MODE_HALT;
        end else if (tick) begin
          ce_next = 1'b1;
        end
      end
      default: state_next = MODE_HALT;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MODE_HALT;
      cpu_ce <= 1'b0;
    end else begin
      state  <= state_next;
      cpu_ce <= ce_next;
    end
  end

  assign mode = state;

`ifdef CPU_STEP_CYCLE_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (cpu_ce) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;
  import cpu_step_pkg::*;

  localparam int DB       = 4;
  localparam int CW       = 32;
  localparam int HALF_DIV = 20;
  localparam int CE_EDGE  = 3;
`ifdef CPU_STEP_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk_50MHz = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clk_div   = 1'b0;
  logic          btn_run   = 1'b0;
  logic          btn_step  = 1'b0;
  logic          halt_req  = 1'b0;
  logic          cpu_ce;
  logic [1:0]    mode;
  logic [CW-1:0] cycle_count;

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;
  int ce_double = 0;
  bit ce_prev   = 1'b0;

  always #5 clk_50MHz = ~clk_50MHz;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk_50MHz   (clk_50MHz),
    .rst_n       (rst_n),
    .clk_div     (clk_div),
    .btn_run     (btn_run),
    .btn_step    (btn_step),
    .halt_req    (halt_req),
    .cpu_ce      (cpu_ce),
    .mode        (mode),
    .cycle_count (cycle_count)
  );

  always @(negedge clk_50MHz) begin
    if (cpu_ce === 1'b1 && ce_prev) ce_double++;
    ce_prev = (cpu_ce === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic press_run(input int n);
    btn_run = 1'b1;
    cycles(n);
    btn_run = 1'b0;
  endtask

  task automatic wait_mode(input string tag, input logic [1:0] m, input int budget);
    int k = 0;
    while (mode !== m && k < budget) begin
      cycles(1);
      k++;
    end
    check(tag, 32'(mode), 32'(m));
  endtask

  // One clk_div period starting now; reports pulse count and the edge of the first pulse.
  task automatic div_period(output int hits, output int first_edge);
    hits       = 0;
    first_edge = 0;
    clk_div    = 1'b1;
    for (int e = 1; e <= 2 * HALF_DIV; e++) begin
      if (e == HALF_DIV + 1) clk_div = 1'b0;
      cycles(1);
      if (cpu_ce === 1'b1) begin
        hits++;
        if (first_edge == 0) first_edge = e;
      end
    end
  endtask

  task automatic count_check(input string tag);
    check(tag, cycle_count, CNT_EN ? 32'(exp_count) : 32'd0);
  endtask

  initial begin
    int hits;
    int first;
    int total;
    int step_cycles;
    int step_ce;
    bit found;

    // reset state
    cycles(2);
    check("rst_mode", 32'(mode), 32'(MODE_HALT));
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_count", cycle_count, 32'd0);
    rst_n = 1'b1;

    // clk_div toggling in HALT gives nothing
    total = 0;
    for (int p = 0; p < 5; p++) begin
      div_period(hits, first);
      total += hits;
    end
    check("halt_no_ce", 32'(total), 32'd0);
    check("halt_mode", 32'(mode), 32'(MODE_HALT));
    count_check("halt_count");

    // enter RUN with a long press, held level gives no second toggle
    press_run(10);
    wait_mode("run_entry", MODE_RUN, 20);
    cycles(20);
    check("run_hold", 32'(mode), 32'(MODE_RUN));
    for (int r = 0; r < 3; r++) begin
      div_period(hits, first);
      check($sformatf("run_pulses%0d", r), 32'(hits), 32'd1);
      check($sformatf("run_edge%0d", r), 32'(first), 32'(CE_EDGE));
      exp_count++;
    end
    count_check("run_count3");

    // back to HALT, then a held step button yields one step
    press_run(10);
    wait_mode("run_exit", MODE_HALT, 20);
    cycles(20);
    step_cycles = 0;
    step_ce     = 0;
    total       = 0;
    btn_step    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) btn_step = 1'b0;
      cycles(1);
      if (cpu_ce === 1'b1) total++;
      if (mode === MODE_STEP) begin
        step_cycles++;
        if (cpu_ce === 1'b1) step_ce++;
      end
    end
    exp_count++;
    check("step_cycles", 32'(step_cycles), 32'd1);
    check("step_ce", 32'(step_ce), 32'd1);
    check("step_total", 32'(total), 32'd1);
    check("step_back", 32'(mode), 32'(MODE_HALT));
    count_check("step_count");

    // halt_req arriving with the tick suppresses the pulse
    press_run(10);
    wait_mode("run_entry2", MODE_RUN, 20);
    clk_div = 1'b1;
    cycles(2);
    halt_req = 1'b1;
    cycles(1);
    check("halt_tick_ce", 32'(cpu_ce), 32'd0);
    check("halt_tick_mode", 32'(mode), 32'(MODE_HALT));
    press_run(10);
    cycles(10);
    check("halt_blocks_run", 32'(mode), 32'(MODE_HALT));
    halt_req = 1'b0;
    clk_div  = 1'b0;
    cycles(20);

    // a 2-cycle glitch is filtered
    press_run(2);
    cycles(20);
    check("glitch_mode", 32'(mode), 32'(MODE_HALT));
    count_check("glitch_count");

    // asynchronous reset while a pulse is out
    press_run(10);
    wait_mode("run_entry3", MODE_RUN, 20);
    clk_div = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_50MHz);
      if (cpu_ce === 1'b1) found = 1'b1;
    end
    check("rst_pulse_seen", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_ce", 32'(cpu_ce), 32'd0);
    check("async_mode", 32'(mode), 32'(MODE_HALT));
    check("async_count", cycle_count, 32'd0);
    cycles(3);
    rst_n   = 1'b1;
    clk_div = 1'b0;
    cycles(5);

    check("no_back_to_back", 32'(ce_double), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
